pipe_stage_elastic: RTL and testbench
=====================================

PIPE_STAGE_ELASTIC -- requirements
Module: pipe_stage_elastic

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data path width in bits.
REQ-002 SHALL have parameter RESET_VALUE, default 0, value loaded into both data registers on reset and flush.
REQ-003 SHALL have parameter CNT_W, default 16, width of the back-pressure counter.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port flush  input  1  kill all held entries this cycle.
REQ-007 SHALL have port hold  input  1  freeze the stage; no accept, no drain.
REQ-008 SHALL have port stat_clr  input  1  synchronous clear of stall_count.
REQ-009 SHALL have port in_valid  input  1  upstream entry offered.
REQ-010 SHALL have port in_ready  output  1  stage can accept this cycle.
REQ-011 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-012 SHALL have port out_valid  output  1  entry presented downstream.
REQ-013 SHALL have port out_ready  input  1  downstream takes the entry this cycle.
REQ-014 SHALL have port out_data  output  WIDTH  payload of the head entry.
REQ-015 SHALL have port occupancy  output  2  held entries: 0, 1 or 2.
REQ-016 SHALL have port stall_count  output  CNT_W  saturating back-pressure cycle count.

Function
REQ-017 SHALL hold two entries: main (head, drives out_data) and skid (second).
REQ-018 SHALL implement states EMPTY (none), ONE (main valid), FULL (main+skid valid); occupancy = 0/1/2 respectively.
REQ-019 SHALL drive in_ready = (state != FULL) & ~hold & ~flush; the FULL term comes from a register, never from out_ready.
REQ-020 SHALL drive out_valid = (state != EMPTY) & ~hold & ~flush.
REQ-021 SHALL define accept = in_valid & in_ready and drain = out_valid & out_ready.
REQ-022 EMPTY: accept -> ONE, main <= in_data; otherwise stay.
REQ-023 ONE: accept & drain -> ONE, main <= in_data; accept only -> FULL, skid <= in_data; drain only -> EMPTY; neither -> stay.
REQ-024 FULL: drain -> ONE, main <= skid; otherwise stay; accept impossible.
REQ-025 SHALL deliver entries in strict acceptance order; no loss, no duplication.
REQ-026 Latency: an entry accepted into EMPTY SHALL appear on out_valid/out_data the next cycle; throughput one entry per cycle when out_ready is held high.
REQ-027 flush SHALL take priority over hold, accept and drain: next state EMPTY, main and skid <= RESET_VALUE, no transfer counted on either side that cycle.
REQ-028 hold SHALL freeze state and both data registers; in_valid/out_ready are ignored while hold=1.
REQ-029 In EMPTY, out_data SHALL retain the last drained value (RESET_VALUE after reset/flush).
REQ-030 stall_count SHALL increment by 1 in each cycle where state != EMPTY and not flush and (hold | ~out_ready).
REQ-031 stall_count SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-032 stat_clr SHALL zero stall_count next cycle and override a same-cycle increment; it SHALL not affect data state.

Reset
REQ-033 rst=1 SHALL immediately force state EMPTY, main and skid = RESET_VALUE, stall_count = 0, regardless of clk.
REQ-034 While rst=1: in_ready=0, out_valid=0, occupancy=0, out_data=RESET_VALUE.
REQ-035 Reset asserted mid-transfer SHALL discard all held entries; the first cycle after release SHALL show in_ready=1 (hold=0, flush=0).

Verification
REQ-036 Streaming: out_ready=1, push 0x11,0x22,0x33 on consecutive cycles -> out_data 0x11,0x22,0x33 on the next three cycles, occupancy never exceeds 1.
REQ-037 Back-pressure: out_ready=0, push 0xA,0xB -> occupancy 2, in_ready=0, 0xC blocked; raise out_ready -> 0xA then 0xB, then 0xC accepted; no loss.
REQ-038 Flush: FULL with 0xA,0xB, assert flush with in_valid=1 and out_ready=1 -> no transfer, next cycle occupancy 0, out_data=RESET_VALUE.
REQ-039 Hold: ONE with 0x5, hold=1 for 3 cycles with in_valid=1, out_ready=1 -> out_valid=0, in_ready=0, stall_count +3, 0x5 delivered after release.
REQ-040 Saturation/clear: CNT_W=2, out_ready=0 with one entry for 6 cycles -> stall_count 3 and holds; stat_clr pulse -> 0.
REQ-041 Async reset: assert rst between clock edges in FULL -> outputs per REQ-034 before the next edge; release -> accepts new data next cycle.

Source files
------------

// File: rtl/pipe_stage_elastic.sv
// rtl/pipe_stage_elastic.sv - two-entry elastic pipeline stage with skid buffer and stall counter
module pipe_stage_elastic #(
   parameter int unsigned      WIDTH       = 32,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter int unsigned      CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             hold,
   input  logic             stat_clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy,
   output logic [CNT_W-1:0] stall_count
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_main;
   logic [WIDTH-1:0] r_skid;
   logic [WIDTH-1:0] w_main_nxt;
   logic [WIDTH-1:0] w_skid_nxt;
   logic [CNT_W-1:0] r_stall;
   logic             w_accept;
   logic             w_drain;
   logic             w_stall_inc;
   logic             w_stall_sat;

   // in_ready depends only on registered state plus the freeze/kill controls,
   // so upstream never sees a combinational path from out_ready.
   // rst is folded in because state is already EMPTY during reset.
   assign in_ready    = (r_state != ST_FULL) & ~hold & ~flush & ~rst;
   assign out_valid   = (r_state != ST_EMPTY) & ~hold & ~flush & ~rst;
   assign w_accept    = in_valid & in_ready;
   assign w_drain     = out_valid & out_ready;
   assign out_data    = r_main;
   assign occupancy   = (r_state == ST_FULL) ? 2'd2 :
                        (r_state == ST_ONE)  ? 2'd1 : 2'd0;
   assign stall_count = r_stall;

   // A held entry that cannot leave this cycle counts as a stall; flush cycles do not.
   assign w_stall_inc = (r_state != ST_EMPTY) & ~flush & (hold | ~out_ready);
   assign w_stall_sat = &r_stall;

   // State and data registers; reset and flush both return to the empty stage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_EMPTY;
         r_main  <= RESET_VALUE;
         r_skid  <= RESET_VALUE;
      end else begin
         r_state <= w_state_nxt;
         r_main  <= w_main_nxt;
         r_skid  <= w_skid_nxt;
      end
   end

   // Next state and data; hold needs no branch since it already blocks accept and drain.
   always_comb begin
      w_state_nxt = r_state;
      w_main_nxt  = r_main;
      w_skid_nxt  = r_skid;
      if (flush) begin
         w_state_nxt = ST_EMPTY;
         w_main_nxt  = RESET_VALUE;
         w_skid_nxt  = RESET_VALUE;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_accept) begin
                  w_state_nxt = ST_ONE;
                  w_main_nxt  = in_data;
               end
            end
            ST_ONE: begin
               if (w_accept && w_drain) begin
                  w_main_nxt = in_data;
               end else if (w_accept) begin
                  w_state_nxt = ST_FULL;
                  w_skid_nxt  = in_data;
               end else if (w_drain) begin
                  w_state_nxt = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (w_drain) begin
                  w_state_nxt = ST_ONE;
                  w_main_nxt  = r_skid;
               end
            end
            default: begin
               w_state_nxt = ST_EMPTY;
            end
         endcase
      end
   end

   // Saturating back-pressure counter; a clear wins over a same-cycle increment.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall <= '0;
      end else if (stat_clr) begin
         r_stall <= '0;
      end else if (w_stall_inc && !w_stall_sat) begin
         r_stall <= r_stall + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb/tb_pipe_stage_elastic.sv - self-checking bench for pipe_stage_elastic
module tb_pipe_stage_elastic;

   localparam logic [31:0] RV        = 32'hC0DE_0001;
   localparam int          CAP_BIG   = 65535;
   localparam int          CAP_SMALL = 3;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        hold;
   logic        stat_clr;
   logic        in_valid;
   logic [31:0] in_data;
   logic        out_ready;
   logic        in_ready;
   logic        out_valid;
   logic [31:0] out_data;
   logic [1:0]  occupancy;
   logic [15:0] stall_count;
   logic        s_in_ready;
   logic        s_out_valid;
   logic [31:0] s_out_data;
   logic [1:0]  s_occupancy;
   logic [1:0]  s_stall_count;

   int checks = 0;
   int errors = 0;

   logic [31:0] mq[$];
   logic [31:0] m_last;
   int          m_st_big;
   int          m_st_small;

   typedef struct {
      logic        iv;
      logic [31:0] id;
      logic        ordy;
      logic [1:0]  e_occ;
      logic        e_ir;
      logic        e_ov;
      logic [31:0] e_od;
      int          e_st;
   } vec_t;

   vec_t tbl[12];

   pipe_stage_elastic #(.WIDTH(32), .RESET_VALUE(RV), .CNT_W(16)) u_dut (
      .clk(clk), .rst(rst), .flush(flush), .hold(hold), .stat_clr(stat_clr),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .occupancy(occupancy), .stall_count(stall_count)
   );

   pipe_stage_elastic #(.WIDTH(32), .RESET_VALUE(RV), .CNT_W(2)) u_sat (
      .clk(clk), .rst(rst), .flush(flush), .hold(hold), .stat_clr(stat_clr),
      .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
      .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
      .occupancy(s_occupancy), .stall_count(s_stall_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic fl, input logic ho, input logic sc,
                        input logic iv, input logic [31:0] id, input logic ordy);
      flush = fl; hold = ho; stat_clr = sc;
      in_valid = iv; in_data = id; out_ready = ordy;
   endtask

   task automatic model_reset();
      mq.delete();
      m_last     = RV;
      m_st_big   = 0;
      m_st_small = 0;
   endtask

   task automatic check_model();
      logic        e_ir;
      logic        e_ov;
      logic [31:0] e_od;
      e_ir = (mq.size() < 2) && !hold && !flush;
      e_ov = (mq.size() > 0) && !hold && !flush;
      e_od = (mq.size() > 0) ? mq[0] : m_last;
      chk("occupancy", occupancy, mq.size());
      chk("in_ready", in_ready, e_ir);
      chk("out_valid", out_valid, e_ov);
      chk("out_data", out_data, e_od);
      chk("stall_count", stall_count, m_st_big);
      chk("stall_count_w2", s_stall_count, m_st_small);
   endtask

   // Queue-level view of the stage: entries leave from the front in arrival order.
   task automatic advance();
      int  sz;
      bit  acc;
      bit  drn;
      bit  inc;
      @(posedge clk);
      sz  = mq.size();
      acc = in_valid && (sz < 2) && !hold && !flush;
      drn = out_ready && (sz > 0) && !hold && !flush;
      inc = (sz > 0) && !flush && (hold || !out_ready);
      if (flush) begin
         mq.delete();
         m_last = RV;
      end else begin
         if (drn) m_last = mq.pop_front();
         if (acc) mq.push_back(in_data);
      end
      if (stat_clr) begin
         m_st_big   = 0;
         m_st_small = 0;
      end else if (inc) begin
         if (m_st_big < CAP_BIG) m_st_big++;
         if (m_st_small < CAP_SMALL) m_st_small++;
      end
      #1;
   endtask

   task automatic step_m(input logic fl, input logic ho, input logic sc,
                         input logic iv, input logic [31:0] id, input logic ordy);
      drive(fl, ho, sc, iv, id, ordy);
      @(negedge clk);
      check_model();
      advance();
   endtask

   initial begin
      // streaming then back-pressure, expectations written out by hand
      tbl[0]  = '{1'b1, 32'h11, 1'b1, 2'd0, 1'b1, 1'b0, RV,    0};
      tbl[1]  = '{1'b1, 32'h22, 1'b1, 2'd1, 1'b1, 1'b1, 32'h11, 0};
      tbl[2]  = '{1'b1, 32'h33, 1'b1, 2'd1, 1'b1, 1'b1, 32'h22, 0};
      tbl[3]  = '{1'b0, 32'h00, 1'b1, 2'd1, 1'b1, 1'b1, 32'h33, 0};
      tbl[4]  = '{1'b0, 32'h00, 1'b0, 2'd0, 1'b1, 1'b0, 32'h33, 0};
      tbl[5]  = '{1'b1, 32'h0A, 1'b0, 2'd0, 1'b1, 1'b0, 32'h33, 0};
      tbl[6]  = '{1'b1, 32'h0B, 1'b0, 2'd1, 1'b1, 1'b1, 32'h0A, 0};
      tbl[7]  = '{1'b1, 32'h0C, 1'b0, 2'd2, 1'b0, 1'b1, 32'h0A, 1};
      tbl[8]  = '{1'b1, 32'h0C, 1'b1, 2'd2, 1'b0, 1'b1, 32'h0A, 2};
      tbl[9]  = '{1'b1, 32'h0C, 1'b1, 2'd1, 1'b1, 1'b1, 32'h0B, 2};
      tbl[10] = '{1'b0, 32'h00, 1'b1, 2'd1, 1'b1, 1'b1, 32'h0C, 2};
      tbl[11] = '{1'b0, 32'h00, 1'b1, 2'd0, 1'b1, 1'b0, 32'h0C, 2};

      rst = 1'b1;
      drive(0, 0, 0, 1, 32'h0, 1);
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_occupancy", occupancy, 0);
      chk("rst_out_data", out_data, RV);
      chk("rst_stall", stall_count, 0);
      drive(0, 0, 0, 0, 32'h0, 0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 12; i++) begin
         drive(0, 0, 0, tbl[i].iv, tbl[i].id, tbl[i].ordy);
         @(negedge clk);
         chk($sformatf("tbl%0d_occupancy", i), occupancy, tbl[i].e_occ);
         chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].e_ir);
         chk($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].e_ov);
         chk($sformatf("tbl%0d_out_data", i), out_data, tbl[i].e_od);
         chk($sformatf("tbl%0d_stall", i), stall_count, tbl[i].e_st);
         advance();
      end

      // flush while full, with both sides offering a transfer
      step_m(0, 0, 0, 1, 32'hA, 0);
      step_m(0, 0, 0, 1, 32'hB, 0);
      drive(1, 0, 0, 1, 32'hDD, 1);
      @(negedge clk);
      chk("flush_in_ready", in_ready, 0);
      chk("flush_out_valid", out_valid, 0);
      check_model();
      advance();
      drive(0, 0, 0, 0, 32'h0, 0);
      @(negedge clk);
      chk("post_flush_occupancy", occupancy, 0);
      chk("post_flush_out_data", out_data, RV);
      check_model();
      advance();

      // hold for three cycles with one entry held
      step_m(0, 0, 1, 0, 32'h0, 1);
      step_m(0, 0, 0, 1, 32'h5, 1);
      repeat (3) step_m(0, 1, 0, 1, 32'h99, 1);
      drive(0, 0, 0, 0, 32'h0, 1);
      @(negedge clk);
      chk("hold_release_data", out_data, 32'h5);
      chk("hold_release_valid", out_valid, 1);
      chk("hold_stall", stall_count, 3);
      check_model();
      advance();

      // saturation of the narrow counter and clear
      step_m(0, 0, 1, 0, 32'h0, 1);
      step_m(0, 0, 0, 1, 32'h7, 1);
      repeat (6) step_m(0, 0, 0, 0, 32'h0, 0);
      drive(0, 0, 0, 0, 32'h0, 0);
      @(negedge clk);
      chk("sat_value", s_stall_count, 3);
      check_model();
      advance();
      step_m(0, 0, 1, 0, 32'h0, 0);
      drive(0, 0, 0, 0, 32'h0, 1);
      @(negedge clk);
      chk("clr_small", s_stall_count, 0);
      chk("clr_big", stall_count, 0);
      check_model();
      advance();

      // asynchronous reset between edges while full
      step_m(0, 0, 0, 1, 32'hA1, 0);
      step_m(0, 0, 0, 1, 32'hB2, 0);
      drive(0, 0, 0, 1, 32'h33, 1);
      #1 rst = 1'b1;
      #1;
      chk("arst_in_ready", in_ready, 0);
      chk("arst_out_valid", out_valid, 0);
      chk("arst_occupancy", occupancy, 0);
      chk("arst_out_data", out_data, RV);
      chk("arst_stall", stall_count, 0);
      @(negedge clk);
      drive(0, 0, 0, 0, 32'h0, 0);
      rst = 1'b0;
      model_reset();
      advance();
      drive(0, 0, 0, 1, 32'h44, 1);
      @(negedge clk);
      chk("arst_release_in_ready", in_ready, 1);
      check_model();
      advance();

      // randomized traffic against the queue model
      for (int i = 0; i < 400; i++) begin
         step_m($urandom_range(15) == 0, $urandom_range(7) == 0, $urandom_range(31) == 0,
                $urandom_range(1), $urandom, $urandom_range(3) != 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
